present_sbox_layer_seq: RTL and testbench
=========================================

// Module: present_sbox_layer_seq
// PURPOSE
//   Sequences the PRESENT substitution layer over a full 64-bit cipher state using LANES
//   shared present_sbox instances, LANES nibbles per cycle. The present_sbox instances
//   also perform the round-key XOR. Sits between the round controller (upstream) and the
//   pLayer/permutation stage (downstream). Trades area for latency.
//   Uses valid/ready handshakes on both sides.
// PARAMETERS
//   LANES   1   sbox instances used in parallel; legal values 1,2,4,8,16 (16 % LANES == 0)
// PORTS
//   clk        in   1   single clock, rising edge
//   rst        in   1   asynchronous, active-high reset
//   in_valid   in   1   upstream offers state/key
//   in_ready   out  1   block can accept a new state/key this cycle
//   in_state   in   64  cipher state; nibble i = in_state[4i+3:4i]
//   in_key     in   64  round-key slice XORed after substitution, nibble-aligned with state
//   abort      in   1   synchronous flush; discards any job in flight
//   out_valid  out  1   out_state holds a completed result
//   out_ready  in   1   downstream accepts out_state
//   out_state  out  64  nibble i = SBOX(state nibble i) ^ key nibble i
//   busy       out  1   high in RUN or DONE
// BEHAVIOUR
//   Reset (async): state=IDLE, grp_cnt=0, state/key/result regs=0, out_valid=0, busy=0, in_ready=1.
//   FSM: IDLE -> RUN on accept; RUN -> DONE on the edge that processes the last group;
//        DONE -> IDLE on out_valid&&out_ready, or DONE -> RUN if a new job is accepted that same edge.
//   in_ready = (IDLE) || (DONE && out_ready); combinational, never depends on in_valid.
//   Accept = in_valid && in_ready: latch in_state/in_key, grp_cnt=0, enter RUN.
//   RUN: each edge feeds nibbles [grp_cnt*LANES +: LANES] through the sboxes.
//        It writes the results into the result reg at the same nibble positions, then grp_cnt++.
//        Groups are processed in ascending order, nibble 0 first.
//   Latency: out_valid rises exactly 16/LANES edges after the accept edge; LANES=16 gives 1 cycle.
//   grp_cnt is $clog2(16/LANES) bits (minimum 1) and wraps to 0 on entering DONE.
//   out_state is registered and stable while out_valid && !out_ready; no changes during backpressure.
//   out_valid deasserts on the handshake edge unless a back-to-back accept occurs.
//   If a back-to-back accept occurs, out_valid deasserts and the block re-enters RUN.
//   out_state is don't-care while out_valid=0; the result reg is not cleared between jobs.
//   abort: highest priority. Next edge: IDLE, out_valid=0, grp_cnt=0.
//     abort overrides a simultaneous accept; in_ready is forced low while abort=1.
//   in_valid while RUN: ignored (in_ready=0); upstream must hold its data.
//   Async rst mid-RUN: job lost, outputs return to reset values immediately.
// STRUCTURE
//   Shared package present_pkg:
//     - typedef enum {IDLE,RUN,DONE} sbox_seq_state_t
//     - localparam NIBBLES=16, STATE_W=64
//     - SBOX constant table, used as the bench reference model
//   Sub-module: LANES instances of present_sbox (4-bit idat, key -> op) inside a generate loop.
//   No other sub-modules. The mux/demux and counter are inline.
// TESTING
//   1) LANES=1, state=0x0123456789ABCDEF, key=0 -> out_state=0xC56B90AD3EF84712,
//      out_valid exactly 16 edges after accept.
//   2) Same state, key=0xFFFFFFFFFFFFFFFF -> 0x3A946F52C107B8ED;
//      repeat with LANES=4 (latency 4) and LANES=16 (latency 1).
//   3) Backpressure: out_ready=0 for 10 cycles after out_valid -> out_state/out_valid stable,
//      in_ready=0; release -> handshake, then IDLE.
//   4) Back-to-back: out_ready=1 and second in_valid in DONE -> second job accepted same edge;
//      results correct and in order; no bubble beyond 16/LANES.
//   5) abort asserted in RUN at grp_cnt=7 with in_valid=1 -> IDLE next edge, no out_valid,
//      no accept; next job produces the correct result.
//   6) rst pulsed asynchronously mid-RUN -> out_valid=0 and busy=0 immediately; in_ready=1 after release.
//   Scoreboard: random state/key, 1000 jobs, random stalls, vs present_pkg SBOX model.

Source files
------------

// File: rtl/present_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : present_pkg
//  Description : Shared types and constants for the PRESENT substitution layer.
//  Revision    : 1.0  initial release
// ============================================================================
package present_pkg;

  localparam int NIBBLES = 16;
  localparam int STATE_W = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sbox_seq_state_t;

  // Nibble i of this constant is SBOX(i).
  localparam logic [63:0] SBOX = 64'h21748FE3DA09B65C;

  function automatic logic [3:0] sbox_lookup(input logic [3:0] nib);
    return SBOX[{nib, 2'b00} +: 4];
  endfunction

endpackage
`default_nettype wire

// File: rtl/present_sbox.sv
`default_nettype none
// ============================================================================
//  Module      : present_sbox
//  Description : One PRESENT 4-bit S-box followed by the round-key nibble XOR.
//  Revision    : 1.0  initial release
// ============================================================================
module present_sbox (
  input  logic [3:0] i_idat,
  input  logic [3:0] i_key,
  output logic [3:0] o_op
);

  logic [3:0] w_sub;

  always_comb begin
    w_sub = 4'h0;
    case (i_idat)
      4'h0: w_sub = 4'hC;
      4'h1: w_sub = 4'h5;
      4'h2: w_sub = 4'h6;
      4'h3: w_sub = 4'hB;
      4'h4: w_sub = 4'h9;
      4'h5: w_sub = 4'h0;
      4'h6: w_sub = 4'hA;
      4'h7: w_sub = 4'hD;
      4'h8: w_sub = 4'h3;
      4'h9: w_sub = 4'hE;
      4'hA: w_sub = 4'hF;
      4'hB: w_sub = 4'h8;
      4'hC: w_sub = 4'h4;
      4'hD: w_sub = 4'h7;
      4'hE: w_sub = 4'h1;
      4'hF: w_sub = 4'h2;
      default: w_sub = 4'h0;
    endcase
  end

  assign o_op = w_sub ^ i_key;

endmodule
`default_nettype wire

// File: rtl/present_sbox_layer_seq.sv
`default_nettype none
// ============================================================================
//  Module      : present_sbox_layer_seq
//  Description : Time-multiplexed PRESENT sBoxLayer + key XOR, LANES nibbles/cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module present_sbox_layer_seq
  import present_pkg::*;
#(
  parameter int LANES = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [STATE_W-1:0] in_state,
  input  logic [STATE_W-1:0] in_key,
  input  logic               abort,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [STATE_W-1:0] out_state,
  output logic               busy
);

  localparam int GROUPS = NIBBLES / LANES;
  localparam int CNT_W  = (GROUPS > 1) ? $clog2(GROUPS) : 1;
  localparam int GRP_W  = 4 * LANES;
  localparam logic [CNT_W-1:0] LAST_GRP = CNT_W'(GROUPS - 1);

  sbox_seq_state_t    r_state;
  logic [CNT_W-1:0]   r_grp_cnt;
  logic [STATE_W-1:0] r_din;
  logic [STATE_W-1:0] r_key;
  logic [STATE_W-1:0] r_result;
  logic               r_out_valid;

  logic [GRP_W-1:0]   w_grp_din;
  logic [GRP_W-1:0]   w_grp_key;
  logic [GRP_W-1:0]   w_grp_out;
  logic               w_accept;
  logic               w_last;

  // Ready in DONE only when the current result leaves on the same edge.
  assign in_ready  = !abort && ((r_state == IDLE) || ((r_state == DONE) && out_ready));
  assign w_accept  = in_valid && in_ready;
  assign w_last    = (r_grp_cnt == LAST_GRP);
  assign w_grp_din = r_din[r_grp_cnt * GRP_W +: GRP_W];
  assign w_grp_key = r_key[r_grp_cnt * GRP_W +: GRP_W];

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    present_sbox u_sbox (
      .i_idat (w_grp_din[4*g +: 4]),
      .i_key  (w_grp_key[4*g +: 4]),
      .o_op   (w_grp_out[4*g +: 4])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_grp_cnt   <= '0;
      r_din       <= '0;
      r_key       <= '0;
      r_result    <= '0;
      r_out_valid <= 1'b0;
    end else if (abort) begin
      r_state     <= IDLE;
      r_grp_cnt   <= '0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_din     <= in_state;
            r_key     <= in_key;
            r_grp_cnt <= '0;
            r_state   <= RUN;
          end
        end
        RUN: begin
          r_result[r_grp_cnt * GRP_W +: GRP_W] <= w_grp_out;
          if (w_last) begin
            r_grp_cnt   <= '0;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end else begin
            r_grp_cnt <= r_grp_cnt + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            if (w_accept) begin
              r_din     <= in_state;
              r_key     <= in_key;
              r_grp_cnt <= '0;
              r_state   <= RUN;
            end else begin
              r_state <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign out_valid = r_out_valid;
  assign out_state = r_result;
  assign busy      = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_present_sbox_layer_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_present_sbox_layer_seq
//  Description : Directed and randomised bench for present_sbox_layer_seq.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_present_sbox_layer_seq;
  import present_pkg::*;

  localparam logic [63:0] ST_A   = 64'h0123456789ABCDEF;
  localparam logic [63:0] ST_B   = 64'hFEDCBA9876543210;
  localparam logic [63:0] K_ONES = 64'hFFFFFFFFFFFFFFFF;
  localparam logic [63:0] EXP_A0 = 64'hC56B90AD3EF84712;
  localparam logic [63:0] EXP_AF = 64'h3A946F52C107B8ED;
  localparam logic [63:0] EXP_B0 = 64'h21748FE3DA09B65C;
  localparam logic [63:0] EXP_BF = 64'hDE8B701C25F649A3;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, abort, out_ready;
  logic [63:0] in_state, in_key;
  logic        in_ready1, in_ready4, in_ready16;
  logic        out_valid1, out_valid4, out_valid16;
  logic        busy1, busy4, busy16;
  logic [63:0] out_state1, out_state4, out_state16;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  present_sbox_layer_seq #(.LANES(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
    .in_state(in_state), .in_key(in_key), .abort(abort),
    .out_valid(out_valid1), .out_ready(out_ready), .out_state(out_state1), .busy(busy1)
  );

  present_sbox_layer_seq #(.LANES(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4),
    .in_state(in_state), .in_key(in_key), .abort(abort),
    .out_valid(out_valid4), .out_ready(out_ready), .out_state(out_state4), .busy(busy4)
  );

  present_sbox_layer_seq #(.LANES(16)) u_dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready16),
    .in_state(in_state), .in_key(in_key), .abort(abort),
    .out_valid(out_valid16), .out_ready(out_ready), .out_state(out_state16), .busy(busy16)
  );

  function automatic logic [63:0] ref_layer(input logic [63:0] s, input logic [63:0] k);
    logic [63:0] r;
    logic [63:0] tbl;
    r   = '0;
    tbl = SBOX;
    for (int i = 0; i < 16; i++)
      r[4*i +: 4] = tbl[{s[4*i +: 4], 2'b00} +: 4] ^ k[4*i +: 4];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts edges until out_valid1 rises; -1 if it never does.
  task automatic wait_out(output int lat);
    lat = -1;
    for (int e = 1; e <= 64; e++) begin
      tick();
      if (out_valid1) begin
        lat = e;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; abort = 1'b0; out_ready = 1'b0;
    in_state = '0; in_key = '0;
    #12;
    n_tests++; if (out_valid1 !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid1); end
    n_tests++; if (busy1 !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy1); end
    n_tests++; if (in_ready1 !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready1); end
    n_tests++; if (out_state1 !== 64'h0) begin n_fail++; $display("FAIL reset_out_state: got %h expected 0", out_state1); end
    rst = 1'b0;
    tick();
    n_tests++; if (in_ready1 !== 1'b1 || busy1 !== 1'b0) begin n_fail++; $display("FAIL reset_release: in_ready %b busy %b expected 1 0", in_ready1, busy1); end
  endtask

  task automatic test_vector(input logic [63:0] st, input logic [63:0] ky, input logic [63:0] exp, input string name);
    int lat1, lat4, lat16;
    in_state = st; in_key = ky; in_valid = 1'b1; out_ready = 1'b0;
    #1;
    n_tests++; if (in_ready1 !== 1'b1) begin n_fail++; $display("FAIL %s_in_ready: got %b expected 1", name, in_ready1); end
    tick();
    in_valid = 1'b0; in_state = ~st; in_key = ~ky;
    lat1 = 0; lat4 = 0; lat16 = 0;
    for (int e = 1; e <= 40; e++) begin
      tick();
      if (out_valid1  && lat1  == 0) lat1  = e;
      if (out_valid4  && lat4  == 0) lat4  = e;
      if (out_valid16 && lat16 == 0) lat16 = e;
    end
    n_tests++; if (lat1 != 16) begin n_fail++; $display("FAIL %s_lat_l1: got %0d expected 16", name, lat1); end
    n_tests++; if (lat4 != 4) begin n_fail++; $display("FAIL %s_lat_l4: got %0d expected 4", name, lat4); end
    n_tests++; if (lat16 != 1) begin n_fail++; $display("FAIL %s_lat_l16: got %0d expected 1", name, lat16); end
    n_tests++; if (out_state1 !== exp) begin n_fail++; $display("FAIL %s_data_l1: got %h expected %h", name, out_state1, exp); end
    n_tests++; if (out_state4 !== exp) begin n_fail++; $display("FAIL %s_data_l4: got %h expected %h", name, out_state4, exp); end
    n_tests++; if (out_state16 !== exp) begin n_fail++; $display("FAIL %s_data_l16: got %h expected %h", name, out_state16, exp); end
    out_ready = 1'b1;
    tick();
    n_tests++;
    if (out_valid1 || out_valid4 || out_valid16 || busy1 || busy4 || busy16) begin
      n_fail++; $display("FAIL %s_drain: valid %b%b%b busy %b%b%b expected all 0", name,
                         out_valid1, out_valid4, out_valid16, busy1, busy4, busy16);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    int lat;
    in_state = ST_A; in_key = K_ONES; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    wait_out(lat);
    n_tests++; if (lat != 16) begin n_fail++; $display("FAIL bp_latency: got %0d expected 16", lat); end
    for (int i = 0; i < 10; i++) begin
      n_tests++;
      if (out_valid1 !== 1'b1 || out_state1 !== EXP_AF || in_ready1 !== 1'b0) begin
        n_fail++; $display("FAIL bp_hold[%0d]: valid %b data %h in_ready %b expected 1 %h 0",
                           i, out_valid1, out_state1, in_ready1, EXP_AF);
      end
      tick();
    end
    out_ready = 1'b1;
    #1;
    n_tests++; if (in_ready1 !== 1'b1) begin n_fail++; $display("FAIL bp_ready_release: got %b expected 1", in_ready1); end
    tick();
    n_tests++; if (out_valid1 !== 1'b0 || busy1 !== 1'b0) begin n_fail++; $display("FAIL bp_to_idle: valid %b busy %b expected 0 0", out_valid1, busy1); end
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    int lat;
    in_state = ST_A; in_key = '0; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    wait_out(lat);
    n_tests++; if (lat != 16) begin n_fail++; $display("FAIL b2b_lat_first: got %0d expected 16", lat); end
    n_tests++; if (out_state1 !== EXP_A0) begin n_fail++; $display("FAIL b2b_data_first: got %h expected %h", out_state1, EXP_A0); end
    in_state = ST_B; in_key = '0; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    n_tests++; if (in_ready1 !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready: got %b expected 1", in_ready1); end
    tick();
    in_valid = 1'b0; in_state = '0;
    n_tests++; if (out_valid1 !== 1'b0 || busy1 !== 1'b1) begin n_fail++; $display("FAIL b2b_rerun: valid %b busy %b expected 0 1", out_valid1, busy1); end
    wait_out(lat);
    n_tests++; if (lat != 16) begin n_fail++; $display("FAIL b2b_lat_second: got %0d expected 16", lat); end
    n_tests++; if (out_state1 !== EXP_B0) begin n_fail++; $display("FAIL b2b_data_second: got %h expected %h", out_state1, EXP_B0); end
    tick();
    n_tests++; if (out_valid1 !== 1'b0 || busy1 !== 1'b0) begin n_fail++; $display("FAIL b2b_to_idle: valid %b busy %b expected 0 0", out_valid1, busy1); end
    out_ready = 1'b0;
  endtask

  task automatic test_abort();
    int lat;
    bit seen;
    in_state = ST_A; in_key = '0; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    repeat (7) tick();
    n_tests++; if (busy1 !== 1'b1 || out_valid1 !== 1'b0) begin n_fail++; $display("FAIL abort_pre: busy %b valid %b expected 1 0", busy1, out_valid1); end
    abort = 1'b1; in_valid = 1'b1; in_state = ST_B; in_key = K_ONES;
    #1;
    n_tests++; if (in_ready1 !== 1'b0) begin n_fail++; $display("FAIL abort_in_ready: got %b expected 0", in_ready1); end
    tick();
    abort = 1'b0; in_valid = 1'b0;
    #1;
    n_tests++;
    if (busy1 !== 1'b0 || out_valid1 !== 1'b0 || in_ready1 !== 1'b1) begin
      n_fail++; $display("FAIL abort_idle: busy %b valid %b in_ready %b expected 0 0 1", busy1, out_valid1, in_ready1);
    end
    seen = 1'b0;
    repeat (20) begin
      tick();
      if (out_valid1 || busy1) seen = 1'b1;
    end
    n_tests++; if (seen) begin n_fail++; $display("FAIL abort_quiet: activity seen 1 expected 0"); end
    in_state = ST_B; in_key = K_ONES; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_out(lat);
    n_tests++; if (lat != 16) begin n_fail++; $display("FAIL abort_next_lat: got %0d expected 16", lat); end
    n_tests++; if (out_state1 !== EXP_BF) begin n_fail++; $display("FAIL abort_next_data: got %h expected %h", out_state1, EXP_BF); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_async_reset();
    bit seen;
    in_state = ST_A; in_key = K_ONES; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    repeat (5) tick();
    n_tests++; if (busy1 !== 1'b1) begin n_fail++; $display("FAIL arst_pre_busy: got %b expected 1", busy1); end
    #2 rst = 1'b1;
    #1;
    n_tests++;
    if (out_valid1 !== 1'b0 || busy1 !== 1'b0 || in_ready1 !== 1'b1 || out_state1 !== 64'h0) begin
      n_fail++; $display("FAIL arst_immediate: valid %b busy %b in_ready %b data %h expected 0 0 1 0",
                         out_valid1, busy1, in_ready1, out_state1);
    end
    #3 rst = 1'b0;
    #1;
    n_tests++; if (in_ready1 !== 1'b1) begin n_fail++; $display("FAIL arst_release_ready: got %b expected 1", in_ready1); end
    seen = 1'b0;
    repeat (20) begin
      tick();
      if (out_valid1) seen = 1'b1;
    end
    n_tests++; if (seen) begin n_fail++; $display("FAIL arst_job_lost: out_valid seen 1 expected 0"); end
  endtask

  task automatic test_scoreboard();
    logic [63:0] st, ky, exp;
    int lat;
    bit got_ready;
    for (int j = 0; j < 1000; j++) begin
      st  = {$urandom, $urandom};
      ky  = {$urandom, $urandom};
      exp = ref_layer(st, ky);
      repeat ($urandom_range(0, 2)) tick();
      in_state = st; in_key = ky; in_valid = 1'b1; out_ready = 1'b0;
      #1;
      got_ready = 1'b0;
      for (int k = 0; k < 64; k++) begin
        if (in_ready1) begin got_ready = 1'b1; break; end
        tick();
      end
      if (!got_ready) begin
        n_tests++; n_fail++; $display("FAIL sb_accept_timeout[%0d]: in_ready 0 expected 1", j);
        in_valid = 1'b0;
        continue;
      end
      tick();
      in_valid = 1'b0; in_state = {$urandom, $urandom}; in_key = {$urandom, $urandom};
      wait_out(lat);
      repeat ($urandom_range(0, 3)) tick();
      n_tests++;
      if (lat != 16 || out_state1 !== exp) begin
        n_fail++; $display("FAIL sb_job[%0d]: lat %0d data %h expected 16 %h", j, lat, out_state1, exp);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_vector(ST_A, 64'h0, EXP_A0, "vec_key0");
    test_vector(ST_A, K_ONES, EXP_AF, "vec_keyF");
    test_backpressure();
    test_back_to_back();
    test_abort();
    test_async_reset();
    test_scoreboard();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
